// File: rtl/tppe_accum_lif.sv
// TPPE accumulator + leaky integrate-and-fire back end.
// Accumulates signed weights per timestep over a beat group, then fires one timestep per cycle.
module tppe_accum_lif #(
  parameter int unsigned TIMESTEPS    = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH    = 12,
  parameter int unsigned LEAK_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WEIGHT_WIDTH-1:0] in_weight,
  input  logic [TIMESTEPS-1:0]    in_spikes,
  input  logic                    in_last,
  input  logic [ACC_WIDTH-1:0]    cfg_threshold,
  input  logic [LEAK_WIDTH-1:0]   cfg_leak_shift,
  input  logic                    cfg_reset_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TIMESTEPS-1:0]    out_spikes,
  output logic [ACC_WIDTH-1:0]    out_membrane,
  output logic                    out_sat,
  output logic                    busy
);

  localparam int unsigned TW = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
  localparam int unsigned XW = ACC_WIDTH + 2;
  localparam logic signed [XW-1:0] WideMax = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] WideMin = {3'b111, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [TW-1:0] LastT = TW'(TIMESTEPS - 1);

  typedef enum logic [1:0] {StAccum, StFire, StOut} state_e;

  // Returns {clamped, value}.
  function automatic logic [ACC_WIDTH:0] sat_fn(input logic signed [XW-1:0] x);
    if (x > WideMax) return {1'b1, WideMax[ACC_WIDTH-1:0]};
    if (x < WideMin) return {1'b1, WideMin[ACC_WIDTH-1:0]};
    return {1'b0, x[ACC_WIDTH-1:0]};
  endfunction

  function automatic logic signed [XW-1:0] sext_acc(input logic [ACC_WIDTH-1:0] a);
    return {{2{a[ACC_WIDTH-1]}}, a};
  endfunction

  function automatic logic signed [XW-1:0] sext_w(input logic [WEIGHT_WIDTH-1:0] w);
    return {{(XW-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
  endfunction

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q [TIMESTEPS];
  logic signed [ACC_WIDTH-1:0]  acc_d [TIMESTEPS];
  logic [ACC_WIDTH:0]           acc_res [TIMESTEPS];
  logic signed [ACC_WIDTH-1:0]  v_q, v_d;
  logic [TIMESTEPS-1:0]         spikes_q, spikes_d;
  logic                         sat_q, sat_d;
  logic [TW-1:0]                t_q, t_d;
  logic signed [ACC_WIDTH-1:0]  thr_q, thr_d;
  logic [LEAK_WIDTH-1:0]        shift_q, shift_d;
  logic                         mode_q, mode_d;

  logic signed [ACC_WIDTH-1:0]  leak;
  logic signed [XW-1:0]         wide_pre, wide_sub;
  logic signed [ACC_WIDTH-1:0]  v_pre, v_sub;
  logic                         clamp_pre, clamp_sub, fire;

  always_comb begin
    for (int i = 0; i < TIMESTEPS; i++) begin
      acc_res[i] = sat_fn(sext_acc(acc_q[i]) + sext_w(in_weight));
    end
  end

  // Membrane datapath for the timestep currently addressed by t_q.
  assign leak     = (shift_q != '0) ? (v_q >>> shift_q) : '0;
  assign wide_pre = sext_acc(v_q) - sext_acc(leak) + sext_acc(acc_q[t_q]);
  assign {clamp_pre, v_pre} = sat_fn(wide_pre);
  assign wide_sub = sext_acc(v_pre) - sext_acc(thr_q);
  assign {clamp_sub, v_sub} = sat_fn(wide_sub);
  assign fire     = (v_pre >= thr_q);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    v_d      = v_q;
    spikes_d = spikes_q;
    sat_d    = sat_q;
    t_d      = t_q;
    thr_d    = thr_q;
    shift_d  = shift_q;
    mode_d   = mode_q;
    unique case (state_q)
      StAccum: begin
        if (in_valid) begin
          for (int i = 0; i < TIMESTEPS; i++) begin
            if (in_spikes[i]) begin
              acc_d[i] = acc_res[i][ACC_WIDTH-1:0];
              if (acc_res[i][ACC_WIDTH]) sat_d = 1'b1;
            end
          end
          if (in_last) begin
            thr_d   = cfg_threshold;
            shift_d = cfg_leak_shift;
            mode_d  = cfg_reset_mode;
            t_d     = '0;
            v_d     = '0;
            state_d = StFire;
          end
        end
      end
      StFire: begin
        if (clamp_pre) sat_d = 1'b1;
        spikes_d[t_q] = fire;
        if (fire) begin
          if (mode_q) begin
            v_d = v_sub;
            if (clamp_sub) sat_d = 1'b1;
          end else begin
            v_d = '0;
          end
        end else begin
          v_d = v_pre;
        end
        if (t_q == LastT) state_d = StOut;
        else              t_d = t_q + TW'(1);
      end
      StOut: begin
        if (out_ready) begin
          for (int i = 0; i < TIMESTEPS; i++) acc_d[i] = '0;
          spikes_d = '0;
          v_d      = '0;
          sat_d    = 1'b0;
          state_d  = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StAccum;
      for (int i = 0; i < TIMESTEPS; i++) acc_q[i] <= '0;
      v_q      <= '0;
      spikes_q <= '0;
      sat_q    <= 1'b0;
      t_q      <= '0;
      thr_q    <= '0;
      shift_q  <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      v_q      <= v_d;
      spikes_q <= spikes_d;
      sat_q    <= sat_d;
      t_q      <= t_d;
      thr_q    <= thr_d;
      shift_q  <= shift_d;
      mode_q   <= mode_d;
    end
  end

  assign in_ready     = (state_q == StAccum);
  assign out_valid    = (state_q == StOut);
  assign busy         = (state_q == StFire) || (state_q == StOut);
  assign out_spikes   = spikes_q;
  assign out_membrane = v_q;
  assign out_sat      = sat_q;

endmodule

// File: tb/tb_tppe_accum_lif.sv
// Directed self-checking bench for tppe_accum_lif with hand-computed LIF results.
module tb_tppe_accum_lif;

  localparam int unsigned TS = 8;
  localparam int unsigned WW = 8;
  localparam int unsigned AW = 12;
  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] in_weight = '0;
  logic [TS-1:0] in_spikes = '0;
  logic          in_last = 1'b0;
  logic [AW-1:0] cfg_threshold = '0;
  logic [LW-1:0] cfg_leak_shift = '0;
  logic          cfg_reset_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TS-1:0] out_spikes;
  logic [AW-1:0] out_membrane;
  logic          out_sat;
  logic          busy;

  int n_total = 0;
  int n_bad = 0;
  int lat;

  always #5 clk = ~clk;

  tppe_accum_lif #(
    .TIMESTEPS   (TS),
    .WEIGHT_WIDTH(WW),
    .ACC_WIDTH   (AW),
    .LEAK_WIDTH  (LW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_weight     (in_weight),
    .in_spikes     (in_spikes),
    .in_last       (in_last),
    .cfg_threshold (cfg_threshold),
    .cfg_leak_shift(cfg_leak_shift),
    .cfg_reset_mode(cfg_reset_mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_spikes    (out_spikes),
    .out_membrane  (out_membrane),
    .out_sat       (out_sat),
    .busy          (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a posedge; presents a beat that is taken on the next edge.
  task automatic send_beat(input logic [WW-1:0] w, input logic [TS-1:0] sp, input logic last);
    in_valid  = 1'b1;
    in_weight = w;
    in_spikes = sp;
    in_last   = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic set_cfg(input logic [AW-1:0] thr, input logic [LW-1:0] sh, input logic md);
    cfg_threshold  = thr;
    cfg_leak_shift = sh;
    cfg_reset_mode = md;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_spikes", out_spikes, 0);
    check_eq("rst_membrane", out_membrane, 0);
    check_eq("rst_sat", out_sat, 0);

    // Two beats, no leak, reset-to-zero.
    set_cfg(12'd7, 3'd0, 1'b0);
    send_beat(8'd5, 8'hFF, 1'b0);
    send_beat(8'd3, 8'h0F, 1'b1);
    check_eq("s1_busy", busy, 1);
    check_eq("s1_in_ready_fire", in_ready, 0);
    wait_valid(lat);
    check_eq("s1_latency", lat, TS);
    check_eq("s1_spikes", out_spikes, 8'hAF);
    check_eq("s1_membrane", out_membrane, 0);
    check_eq("s1_sat", out_sat, 0);
    drain();
    check_eq("s1_in_ready_after", in_ready, 1);
    check_eq("s1_out_valid_after", out_valid, 0);

    // Leak shift 1, subtract-threshold reset.
    set_cfg(12'd15, 3'd1, 1'b1);
    send_beat(8'd10, 8'hFF, 1'b1);
    wait_valid(lat);
    check_eq("s2_out_valid", out_valid, 1);
    check_eq("s2_spikes", out_spikes, 8'hAA);
    check_eq("s2_membrane", out_membrane, 0);
    // Backpressure with stray beats that must not be taken.
    in_valid  = 1'b1;
    in_weight = 8'd100;
    in_spikes = 8'hFF;
    in_last   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_spikes", out_spikes, 8'hAA);
      check_eq("bp_membrane", out_membrane, 0);
      check_eq("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("bp_sat", out_sat, 0);
    drain();
    check_eq("bp_in_ready_after", in_ready, 1);

    // Positive saturation.
    set_cfg(12'd2047, 3'd0, 1'b0);
    for (int i = 0; i < 20; i++) send_beat(8'h7F, 8'h01, (i == 19));
    wait_valid(lat);
    check_eq("s3p_spikes", out_spikes, 8'h01);
    check_eq("s3p_membrane", out_membrane, 0);
    check_eq("s3p_sat", out_sat, 1);
    drain();

    // Negative saturation.
    for (int i = 0; i < 20; i++) send_beat(8'h80, 8'h01, (i == 19));
    wait_valid(lat);
    check_eq("s3n_spikes", out_spikes, 8'h00);
    check_eq("s3n_membrane", out_membrane, 12'h800);
    check_eq("s3n_sat", out_sat, 1);
    drain();
    check_eq("s3n_sat_cleared", out_sat, 0);

    // Config change during FIRE must not affect the group.
    set_cfg(12'd7, 3'd0, 1'b0);
    send_beat(8'd5, 8'hFF, 1'b0);
    send_beat(8'd3, 8'h0F, 1'b1);
    set_cfg(12'd100, 3'd2, 1'b1);
    wait_valid(lat);
    check_eq("s5_spikes", out_spikes, 8'hAF);
    check_eq("s5_membrane", out_membrane, 0);
    drain();

    // Reset in the middle of FIRE.
    set_cfg(12'd7, 3'd0, 1'b0);
    send_beat(8'd5, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("s6_rst_out_valid", out_valid, 0);
    check_eq("s6_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("s6_in_ready", in_ready, 1);
    check_eq("s6_busy", busy, 0);
    set_cfg(12'd1, 3'd0, 1'b0);
    @(posedge clk); #1;
    send_beat(8'd1, 8'h01, 1'b1);
    wait_valid(lat);
    check_eq("s6_latency", lat, TS);
    check_eq("s6_spikes", out_spikes, 8'h01);
    check_eq("s6_membrane", out_membrane, 0);
    check_eq("s6_sat", out_sat, 0);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
